// File: rtl/im_loader.sv
// Boot-time instruction-memory loader: receives a length-prefixed, checksummed
// byte stream, writes the assembled big-endian words and releases the CPU on success.
module im_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        im_we,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_CHECK, S_DONE, S_ERR
  } state_t;

  localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

  // Running XOR checksum over the instruction bytes.
  function automatic logic [7:0] csum_update(input logic [7:0] csum, input logic [7:0] data);
    csum_update = csum ^ data;
  endfunction

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [31:0] word_q, word_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [7:0]  csum_q, csum_d;
  logic [15:0] words_loaded_q, words_loaded_d;
  logic [31:0] im_addr_q, im_addr_d;
  logic [31:0] im_wdata_q, im_wdata_d;
  logic        im_we_q, im_we_d;
  logic        in_ready_q, in_ready_d;
  logic        cpu_hold_q, cpu_hold_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        byte_fire_s;

  assign byte_fire_s = in_valid && in_ready_q;

  // Next-state and datapath decode; outputs are derived from the next state so they stay registered.
  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    word_d         = word_q;
    byte_idx_d     = byte_idx_q;
    csum_d         = csum_q;
    words_loaded_d = words_loaded_q;
    im_addr_d      = im_addr_q;
    im_wdata_d     = im_wdata_q;
    im_we_d        = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d        = S_LEN_HI;
          words_loaded_d = 16'd0;
          csum_d         = 8'd0;
          byte_idx_d     = 2'd0;
        end else begin
          state_d = state_q;
        end
      end
      S_LEN_HI: begin
        if (byte_fire_s) begin
          len_d   = {in_data, len_q[7:0]};
          state_d = S_LEN_LO;
        end else begin
          state_d = state_q;
        end
      end
      S_LEN_LO: begin
        if (byte_fire_s) begin
          len_d = {len_q[15:8], in_data};
          if ((len_d == 16'd0) || ({1'b0, len_d} > MAX_LEN)) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_DATA: begin
        if (byte_fire_s) begin
          word_d     = {word_q[23:0], in_data};
          csum_d     = csum_update(csum_q, in_data);
          byte_idx_d = byte_idx_q + 2'd1;
          // Fourth byte completes the word; the write address is captured here for the WRITE cycle.
          if (byte_idx_q == 2'd3) begin
            state_d    = S_WRITE;
            im_we_d    = 1'b1;
            im_wdata_d = word_d;
            im_addr_d  = BASE_ADDR + {14'd0, words_loaded_q, 2'b00};
          end else begin
            state_d = state_q;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_WRITE: begin
        words_loaded_d = words_loaded_q + 16'd1;
        if (words_loaded_d == len_q) begin
          state_d = S_CHECK;
        end else begin
          state_d = S_DATA;
        end
      end
      S_CHECK: begin
        if (byte_fire_s) begin
          if (in_data == csum_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ERR;
          end
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                 (state_d == S_DATA)   || (state_d == S_CHECK);
    done_d     = (state_d == S_DONE);
    error_d    = (state_d == S_ERR);
    cpu_hold_d = (state_d != S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      len_q          <= 16'd0;
      word_q         <= 32'd0;
      byte_idx_q     <= 2'd0;
      csum_q         <= 8'd0;
      words_loaded_q <= 16'd0;
      im_addr_q      <= BASE_ADDR;
      im_wdata_q     <= 32'd0;
      im_we_q        <= 1'b0;
      in_ready_q     <= 1'b0;
      cpu_hold_q     <= 1'b1;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      word_q         <= word_d;
      byte_idx_q     <= byte_idx_d;
      csum_q         <= csum_d;
      words_loaded_q <= words_loaded_d;
      im_addr_q      <= im_addr_d;
      im_wdata_q     <= im_wdata_d;
      im_we_q        <= im_we_d;
      in_ready_q     <= in_ready_d;
      cpu_hold_q     <= cpu_hold_d;
      done_q         <= done_d;
      error_q        <= error_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign im_we        = im_we_q;
  assign im_addr      = im_addr_q;
  assign im_wdata     = im_wdata_q;
  assign cpu_hold     = cpu_hold_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_im_loader.sv
// Randomized self-checking bench for im_loader against a word-list reference model.
module tb_im_loader;

  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam int          MAXW = 256;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready, im_we, cpu_hold, done, error;
  logic [31:0] im_addr, im_wdata;
  logic [15:0] words_loaded;

  int checks = 0;
  int failures = 0;

  logic [63:0] wr_q[$];
  logic [31:0] words_q[$];
  int          rdy_viol = 0;

  im_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clock(clock), .reset(reset), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .im_we(im_we), .im_addr(im_addr),
    .im_wdata(im_wdata), .cpu_hold(cpu_hold), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  always #5 clock = ~clock;

  // Write capture: every strobe cycle is recorded and must not accept a byte.
  always @(negedge clock) begin
    if (im_we === 1'b1) begin
      wr_q.push_back({im_addr, im_wdata});
      if (in_ready !== 1'b0) rdy_viol++;
    end
  end

  function automatic logic [7:0] model_csum();
    logic [7:0] c = 8'd0;
    foreach (words_q[i]) c = c ^ words_q[i][31:24] ^ words_q[i][23:16] ^ words_q[i][15:8] ^ words_q[i][7:0];
    return c;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clock);
    while (in_ready !== 1'b1 && t < 50) begin
      @(negedge clock);
      t++;
    end
    if (t >= 50) begin
      checks++; failures++;
      $display("FAIL send_byte_timeout: in_ready=%b required 1", in_ready);
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (gap) @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic begin_load(input string name);
    wr_q.delete();
    rdy_viol = 0;
    pulse_start();
    checks++;
    if ({in_ready, cpu_hold, done, error, words_loaded} !== {1'b1, 1'b1, 1'b0, 1'b0, 16'd0}) begin
      failures++;
      $display("FAIL %s_start: rdy/hold/done/err/wl=%b%b%b%b/%0d required 1100/0", name,
               in_ready, cpu_hold, done, error, words_loaded);
    end
  endtask

  task automatic send_stream(input int max_gap, input bit corrupt, input int glitch_at);
    logic [7:0]  cs;
    logic [31:0] w;
    int          n;
    int          k = 0;
    n  = words_q.size();
    cs = model_csum();
    if (corrupt) cs = cs ^ 8'(1 << $urandom_range(0, 7));
    send_byte(8'(n >> 8), $urandom_range(0, max_gap));
    send_byte(8'(n), $urandom_range(0, max_gap));
    foreach (words_q[i]) begin
      w = words_q[i];
      for (int b = 0; b < 4; b++) begin
        if (k == glitch_at) pulse_start();
        send_byte(w[8*(3-b) +: 8], $urandom_range(0, max_gap));
        k++;
      end
    end
    send_byte(cs, $urandom_range(0, max_gap));
  endtask

  task automatic check_load(input string name, input bit exp_done);
    logic [63:0] exp_wr;
    checks++;
    if (wr_q.size() != words_q.size()) begin
      failures++;
      $display("FAIL %s_write_count: got %0d required %0d", name, wr_q.size(), words_q.size());
    end
    for (int i = 0; i < wr_q.size() && i < words_q.size(); i++) begin
      exp_wr = {BASE + 32'(4 * i), words_q[i]};
      checks++;
      if (wr_q[i] !== exp_wr) begin
        failures++;
        $display("FAIL %s_write%0d: addr/data=%h required %h", name, i, wr_q[i], exp_wr);
      end
    end
    checks++;
    if ({done, error, cpu_hold, in_ready} !== {exp_done, !exp_done, !exp_done, 1'b0}) begin
      failures++;
      $display("FAIL %s_status: done/err/hold/rdy=%b%b%b%b required %b%b%b0", name,
               done, error, cpu_hold, in_ready, exp_done, !exp_done, !exp_done);
    end
    checks++;
    if (words_loaded !== 16'(words_q.size())) begin
      failures++;
      $display("FAIL %s_words_loaded: got %0d required %0d", name, words_loaded, words_q.size());
    end
    checks++;
    if (rdy_viol != 0) begin
      failures++;
      $display("FAIL %s_ready_in_write: got %0d violations required 0", name, rdy_viol);
    end
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if ({in_ready, im_we, im_addr, im_wdata, cpu_hold, done, error, words_loaded} !==
        {1'b0, 1'b0, BASE, 32'd0, 1'b1, 1'b0, 1'b0, 16'd0}) begin
      failures++;
      $display("FAIL %s: rdy=%b we=%b addr=%h wdata=%h hold=%b done=%b err=%b wl=%0d required 0 0 %h 0 1 0 0 0",
               name, in_ready, im_we, im_addr, im_wdata, cpu_hold, done, error, words_loaded, BASE);
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #1 check_reset_values("reset_values");
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;
    check_reset_values("idle_after_reset");
  endtask

  task automatic test_one_word();
    words_q = '{32'h2008_0005};
    begin_load("one_word");
    send_stream(0, 1'b0, -1);
    check_load("one_word", 1'b1);
  endtask

  task automatic test_gaps();
    words_q = '{$urandom, $urandom, $urandom};
    begin_load("gaps");
    send_stream(3, 1'b0, -1);
    check_load("gaps", 1'b1);
  endtask

  task automatic test_bad_csum();
    words_q = '{32'h2008_0005};
    begin_load("bad_csum");
    send_stream(1, 1'b1, -1);
    check_load("bad_csum", 1'b0);
    words_q = '{32'h2008_0005};
    begin_load("after_bad");
    send_stream(1, 1'b0, -1);
    check_load("after_bad", 1'b1);
  endtask

  task automatic test_bad_len();
    logic [15:0] lens[2] = '{16'd0, 16'd257};
    foreach (lens[i]) begin
      begin_load("bad_len");
      send_byte(lens[i][15:8], 0);
      send_byte(lens[i][7:0], 0);
      checks++;
      if ({error, done, cpu_hold, in_ready} !== {(lens[i] == 16'd0) || (lens[i] > 16'(MAXW)), 1'b0, 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL bad_len_%0d: err/done/hold/rdy=%b%b%b%b required 1010", lens[i], error, done, cpu_hold, in_ready);
      end
      repeat (3) @(posedge clock); #1;
      checks++;
      if (wr_q.size() != 0) begin
        failures++;
        $display("FAIL bad_len_%0d_writes: got %0d required 0", lens[i], wr_q.size());
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] w;
    words_q = '{$urandom, $urandom, $urandom};
    begin_load("reset_mid");
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    for (int i = 0; i < 6; i++) begin
      w = words_q[i / 4];
      send_byte(w[8*(3 - i % 4) +: 8], 0);
    end
    reset = 1'b0;
    #1 check_reset_values("reset_mid_values");
    checks++;
    if (wr_q.size() != 1) begin
      failures++;
      $display("FAIL reset_mid_partial: got %0d writes required 1", wr_q.size());
    end
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    begin_load("reset_reload");
    send_stream(2, 1'b0, -1);
    check_load("reset_reload", 1'b1);
  endtask

  task automatic test_start_in_data();
    words_q = '{$urandom, $urandom};
    begin_load("start_in_data");
    send_stream(1, 1'b0, 2);
    check_load("start_in_data", 1'b1);
  endtask

  task automatic test_max_len();
    words_q.delete();
    for (int i = 0; i < MAXW; i++) words_q.push_back($urandom);
    begin_load("max_len");
    send_stream(0, 1'b0, -1);
    check_load("max_len", 1'b1);
  endtask

  task automatic test_random();
    bit bad;
    int n;
    for (int r = 0; r < 5; r++) begin
      n = $urandom_range(1, 8);
      bad = ($urandom_range(0, 2) == 0);
      words_q.delete();
      for (int i = 0; i < n; i++) words_q.push_back($urandom);
      begin_load("random");
      send_stream(2, bad, -1);
      check_load("random", !bad);
    end
  endtask

  initial begin
    test_reset();
    test_one_word();
    test_gaps();
    test_bad_csum();
    test_bad_len();
    test_reset_mid();
    test_start_in_data();
    test_max_len();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/im_loader.md
Name: im_loader

Overview:
- Boot-time program loader; the write side of instruction memory, which the single-cycle CPU only reads.
- Accepts a byte stream with a valid/ready handshake: 16-bit word count, then big-endian 32-bit instruction words, then an XOR checksum byte.
- Assembles the words and writes them into instruction memory at consecutive word addresses.
- Holds the CPU in reset until a load completes without error.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first word written.
- MAX_WORDS, 256, largest accepted word count (instruction memory depth).

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a load from IDLE, DONE or ERR; ignored in other states.
- in_valid  input  1  in_data holds a byte.
- in_data  input  8  stream byte.
- in_ready  output  1  loader can accept a byte this cycle; a byte transfers when in_valid and in_ready are both 1.
- im_we  output  1  instruction memory write strobe, one cycle per word.
- im_addr  output  32  byte address of the write, word aligned.
- im_wdata  output  32  instruction word to write.
- cpu_hold  output  1  1 keeps the CPU pc/gpr in reset.
- done  output  1  level; load completed and checksum matched.
- error  output  1  level; load rejected.
- words_loaded  output  16  count of words written in the current load.

Behaviour:
- Reset values (reset low, asynchronous): state IDLE; in_ready=0, im_we=0, im_addr=BASE_ADDR, im_wdata=0, cpu_hold=1, done=0, error=0, words_loaded=0. Checksum, byte index and length registers are all cleared.
- States: IDLE, LEN_HI, LEN_LO, DATA, WRITE, CHECK, DONE, ERR.
- IDLE: in_ready=0. start moves to LEN_HI.
- Starting a load: start moves to LEN_HI from IDLE, DONE or ERR. On that transition, cpu_hold=1, done=0, error=0, words_loaded=0, checksum=0 and byte index=0.
- LEN_HI: in_ready=1. An accepted byte becomes len[15:8]. Next state LEN_LO.
- LEN_LO: in_ready=1. An accepted byte becomes len[7:0].
  - If len==0 or len>MAX_WORDS, next state is ERR.
  - Otherwise next state is DATA.
- DATA: in_ready=1. Each accepted byte shifts into the word register MSB-first (first byte becomes bits [31:24]) and is XORed into the checksum. On the 4th byte, next state is WRITE.
- WRITE (exactly 1 cycle):
  - im_we=1, im_wdata=assembled word, im_addr=BASE_ADDR+4*words_loaded, in_ready=0.
  - words_loaded increments at the end of the cycle.
  - If the incremented count equals len, next state is CHECK; otherwise DATA.
- Latency: im_we asserts in the cycle after the 4th byte of a word is accepted.
- Outside WRITE: im_we=0; im_addr and im_wdata hold their last values.
- CHECK: in_ready=1. The accepted byte is compared with the checksum.
  - Equal: next state DONE.
  - Not equal: next state ERR.
- DONE: done=1, cpu_hold=0, in_ready=0.
- ERR: error=1, cpu_hold=1, in_ready=0.
- in_valid gaps in any receiving state: state and registers hold; there is no timeout.
- start while in LEN_HI..CHECK: ignored; the load continues unaffected.
- Addresses: 32-bit adds; no wrap is possible because len<=MAX_WORDS.
- Reset mid-load: immediate return to reset values. A partial memory image is left as written; cpu_hold stays 1 until a later successful load.

Test Plan:
- One-word load: start, then bytes 00 01 20 08 00 05 2D (checksum 20^08^00^05=2D) -> single im_we, addr 0x0, wdata 0x20080005. Then done=1, cpu_hold=0, words_loaded=1.
- Three-word load with in_valid low 1–3 cycles between bytes, BASE_ADDR=0x100 -> writes at 0x100, 0x104 and 0x108 with the correct words; in_ready=0 in each WRITE cycle; done=1.
- Bad checksum: the one-word stream with last byte 2C -> word is written, then error=1, done=0, cpu_hold=1. A following start plus a correct stream -> done=1.
- Length 0 (00 00) and length 257 (01 01) -> ERR right after the LEN_LO byte; no im_we; error=1.
- reset low for 1 cycle after 2 bytes of word 2 -> all outputs return to reset values at once. A new start plus full stream -> completes normally with words_loaded starting at 0.
- start pulsed during DATA -> no effect; the load finishes with the correct addresses and done=1.
